// File: rtl/mem_req_arbiter.sv
// Memory request arbiter: grants one of ICache fetch, LSB and prefetcher to a
// single-port memory controller, holds the command until mc_done, then pulses the winner's valid.
module mem_req_arbiter #(
    parameter int         STARVE_LIMIT = 8,
    parameter int         CNT_W        = 4,
    parameter logic [5:0] FETCH_OP     = 6'd2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,
    input  logic        pf_req,
    input  logic [31:0] pf_addr,
    output logic        pf_valid,
    output logic [31:0] pf_data,
    input  logic        lsb_req,
    input  logic        lsb_lors,
    input  logic [5:0]  lsb_op,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata,
    output logic        mc_req,
    output logic [1:0]  mc_kind,
    output logic [5:0]  mc_op,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_COOL} state_t;

    localparam logic [1:0]       KIND_FETCH = 2'd0;
    localparam logic [1:0]       KIND_LOAD  = 2'd1;
    localparam logic [1:0]       KIND_STORE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(STARVE_LIMIT);

    state_t            state_reg, state_next;
    logic [2:0]        owner_reg;        // one-hot: bit0 IC, bit1 PF, bit2 LSB
    logic [CNT_W-1:0]  starve_cnt_reg;
    logic              flush_pend_reg;
    logic              mc_req_reg;
    logic [1:0]        mc_kind_reg;
    logic [5:0]        mc_op_reg;
    logic [31:0]       mc_addr_reg;
    logic [31:0]       mc_wdata_reg;

    logic ic_win, pf_win, lsb_win, grant_any;
    logic starve_hit, owner_store, resp_fire;

    assign starve_hit  = (starve_cnt_reg >= CNT_LIMIT);
    assign owner_store = (mc_kind_reg == KIND_STORE);
    assign grant_any   = ic_win | pf_win | lsb_win;

    // A flush in IDLE blocks arbitration for that cycle.
    always_comb begin
        ic_win  = 1'b0;
        pf_win  = 1'b0;
        lsb_win = 1'b0;
        if (state_reg == S_IDLE && !rob_clear) begin
            if (ic_req && (!lsb_req || starve_hit))
                ic_win = 1'b1;
            else if (lsb_req)
                lsb_win = 1'b1;
            else if (pf_req)
                pf_win = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state_reg <= S_IDLE;
        else if (rdy_in)
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant_any) state_next = S_BUSY;
            S_BUSY:  if (mc_done)   state_next = S_RESP;
            S_RESP:  state_next = S_COOL;
            default: state_next = S_IDLE;
        endcase
    end

    // A flush arriving in the RESP cycle itself must also kill the pulse.
    always_comb begin
        resp_fire = 1'b0;
        if (state_reg == S_RESP)
            resp_fire = owner_store || !(flush_pend_reg || rob_clear);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            owner_reg      <= '0;
            starve_cnt_reg <= '0;
            flush_pend_reg <= 1'b0;
            mc_req_reg     <= 1'b0;
            mc_kind_reg    <= '0;
            mc_op_reg      <= '0;
            mc_addr_reg    <= '0;
            mc_wdata_reg   <= '0;
        end else if (rdy_in) begin
            case (state_reg)
                S_IDLE: begin
                    if (!ic_req || ic_win)
                        starve_cnt_reg <= '0;
                    else if (lsb_win && starve_cnt_reg != CNT_MAX)
                        starve_cnt_reg <= starve_cnt_reg + 1'b1;
                    if (grant_any) begin
                        mc_req_reg <= 1'b1;
                        owner_reg  <= {lsb_win, pf_win, ic_win};
                    end
                    if (ic_win) begin
                        mc_kind_reg  <= KIND_FETCH;
                        mc_op_reg    <= FETCH_OP;
                        mc_addr_reg  <= ic_addr;
                        mc_wdata_reg <= '0;
                    end else if (lsb_win) begin
                        mc_kind_reg  <= lsb_lors ? KIND_STORE : KIND_LOAD;
                        mc_op_reg    <= lsb_op;
                        mc_addr_reg  <= lsb_addr;
                        mc_wdata_reg <= lsb_wdata;
                    end else if (pf_win) begin
                        mc_kind_reg  <= KIND_FETCH;
                        mc_op_reg    <= FETCH_OP;
                        mc_addr_reg  <= pf_addr;
                        mc_wdata_reg <= '0;
                    end
                end
                S_BUSY: begin
                    if (rob_clear && !owner_store)
                        flush_pend_reg <= 1'b1;
                    if (mc_done)
                        mc_req_reg <= 1'b0;
                end
                S_RESP: flush_pend_reg <= 1'b0;
                default: owner_reg <= '0;
            endcase
        end
    end

    // Per-requester result register and valid pulse.
    for (genvar gi = 0; gi < 3; gi++) begin : g_resp
        logic [31:0] data_reg;
        logic        valid;

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in)
                data_reg <= '0;
            else if (rdy_in && state_reg == S_BUSY && mc_done && owner_reg[gi])
                data_reg <= mc_rdata;
        end

        assign valid = resp_fire && owner_reg[gi];
    end

    assign ic_valid  = g_resp[0].valid;
    assign pf_valid  = g_resp[1].valid;
    assign lsb_valid = g_resp[2].valid;
    assign ic_data   = g_resp[0].data_reg;
    assign pf_data   = g_resp[1].data_reg;
    assign lsb_rdata = g_resp[2].data_reg;

    assign mc_req   = mc_req_reg;
    assign mc_kind  = mc_kind_reg;
    assign mc_op    = mc_op_reg;
    assign mc_addr  = mc_addr_reg;
    assign mc_wdata = mc_wdata_reg;

endmodule
